// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target responder.
package i2c_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WRITE_BYTE,
        WRITE_ACK,
        READ_BYTE,
        READ_ACK,
        IGNORE
    } tgt_state_t;

    localparam logic I2C_ACK    = 1'b0;
    localparam logic I2C_NACK   = 1'b1;
    localparam int   I2C_ADDR_W = 7;

endpackage

// File: rtl/i2c_line_sync.sv
// Bus line conditioner: synchronizer chain, optional glitch filter and edge detect.
// Optional filter enabled by defining I2C_TARGET_GLITCH_FILTER_EN.
module i2c_line_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_in,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;
    logic                   line_clean;

    assign sync_d[0] = line_in;
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
        assign sync_d[gi] = sync_q[gi-1];
    end

    // Idle bus is high, so reset to 1 to avoid a spurious edge on release.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

`ifdef I2C_TARGET_GLITCH_FILTER_EN
    localparam int CNT_W = $clog2(FILT_LEN + 1);

    logic [CNT_W-1:0] filt_cnt_q;
    logic [CNT_W-1:0] filt_cnt_d;
    logic             filt_q;
    logic             filt_d;

    // The counter tracks how many consecutive samples disagree with the
    // filtered level; the level flips on the FILT_LEN-th one.
    always_comb begin
        filt_cnt_d = '0;
        filt_d     = filt_q;
        if (sync_q[SYNC_STAGES-1] != filt_q) begin
            if (filt_cnt_q == CNT_W'(FILT_LEN - 1)) begin
                filt_d = sync_q[SYNC_STAGES-1];
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            filt_cnt_q <= '0;
            filt_q     <= 1'b1;
        end else begin
            filt_cnt_q <= filt_cnt_d;
            filt_q     <= filt_d;
        end
    end

    assign line_clean = filt_d;
`else
    assign line_clean = sync_q[SYNC_STAGES-1];
`endif

    assign prev_d = line_clean;

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign level = line_clean;
    assign rise  = line_clean & ~prev_q;
    assign fall  = ~line_clean & prev_q;

endmodule

// File: rtl/i2c_target_responder.sv
// I2C target: address match, write ACK/NACK to host, read data service, no clock stretching.
// Build option I2C_TARGET_GLITCH_FILTER_EN adds a glitch filter on SCL/SDA.
module i2c_target_responder
    import i2c_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  I2C_SCL,
    inout  wire                   I2C_SDA,
    input  logic [I2C_ADDR_W-1:0] own_addr,
    output logic [7:0]            rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    input  logic [7:0]            tx_data,
    output logic                  tx_load,
    output logic                  busy,
    output logic                  start_det,
    output logic                  stop_det
);

    localparam int         SYNC_N    = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
    localparam logic [3:0] BIT_LAST  = 4'd7;
    localparam logic [3:0] ACK_SLOT  = 4'd8;

    logic scl_level, scl_rise, scl_fall;
    logic sda_level, sda_rise, sda_fall;
    logic start_cond, stop_cond;
    logic sda_drive;

    i2c_line_sync #(.SYNC_STAGES(SYNC_N), .FILT_LEN(FILT_LEN)) u_scl_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (I2C_SCL),
        .level   (scl_level),
        .rise    (scl_rise),
        .fall    (scl_fall)
    );

    i2c_line_sync #(.SYNC_STAGES(SYNC_N), .FILT_LEN(FILT_LEN)) u_sda_sync (
        .clk     (clk),
        .rst     (rst),
        .line_in (I2C_SDA),
        .level   (sda_level),
        .rise    (sda_rise),
        .fall    (sda_fall)
    );

    assign start_cond = sda_fall & scl_level;
    assign stop_cond  = sda_rise & scl_level;

    tgt_state_t            state_q, state_d;
    logic [3:0]            bit_cnt_q, bit_cnt_d;
    logic [7:0]            shift_q, shift_d;
    logic                  rw_q, rw_d;
    logic [I2C_ADDR_W-1:0] own_addr_q, own_addr_d;
    logic                  sda_low_q, sda_low_d;
    logic [7:0]            rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  tx_load_q, tx_load_d;
    logic                  busy_q, busy_d;
    logic                  start_det_q, start_det_d;
    logic                  stop_det_q, stop_det_d;

    // bit_cnt counts SCL rises within a byte; ACK_SLOT marks the ACK clock
    // before its rise, and 0 marks it after the rise (waiting for the fall).
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        own_addr_d  = own_addr_q;
        sda_low_d   = sda_low_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        tx_load_d   = 1'b0;
        busy_d      = busy_q;
        start_det_d = start_cond;
        stop_det_d  = stop_cond;

        if (start_cond) begin
            state_d    = ADDR;
            bit_cnt_d  = '0;
            own_addr_d = own_addr;
            sda_low_d  = 1'b0;
        end else if (stop_cond) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            sda_low_d = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    sda_low_d = 1'b0;
                end
                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_level};
                        if (bit_cnt_q == BIT_LAST) begin
                            rw_d = sda_level;
                            if (shift_q[6:0] == own_addr_q) begin
                                state_d   = ADDR_ACK;
                                bit_cnt_d = ACK_SLOT;
                                busy_d    = 1'b1;
                            end else begin
                                state_d   = IGNORE;
                                bit_cnt_d = '0;
                                busy_d    = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                ADDR_ACK, READ_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = '0;
                        if (state_q == READ_ACK && sda_level == I2C_NACK) begin
                            state_d = IGNORE;
                            busy_d  = 1'b0;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == ACK_SLOT) begin
                            sda_low_d = (state_q == ADDR_ACK) ? ~I2C_ACK : 1'b0;
                        end else if (state_q == ADDR_ACK && !rw_q) begin
                            sda_low_d = 1'b0;
                            state_d   = WRITE_BYTE;
                        end else begin
                            // First data bit goes out on this same falling edge.
                            shift_d   = {tx_data[6:0], 1'b0};
                            sda_low_d = ~tx_data[7];
                            tx_load_d = 1'b1;
                            state_d   = READ_BYTE;
                        end
                    end
                end
                WRITE_BYTE: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[6:0], sda_level};
                        if (bit_cnt_q == BIT_LAST) begin
                            rx_data_d  = {shift_q[6:0], sda_level};
                            rx_valid_d = 1'b1;
                            if (rx_ready) begin
                                state_d   = WRITE_ACK;
                                bit_cnt_d = ACK_SLOT;
                            end else begin
                                state_d   = IGNORE;
                                bit_cnt_d = '0;
                                busy_d    = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                WRITE_ACK: begin
                    if (scl_rise) begin
                        bit_cnt_d = '0;
                    end else if (scl_fall) begin
                        if (bit_cnt_q == ACK_SLOT) begin
                            sda_low_d = 1'b1;
                        end else begin
                            sda_low_d = 1'b0;
                            state_d   = WRITE_BYTE;
                        end
                    end
                end
                READ_BYTE: begin
                    if (scl_rise) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = READ_ACK;
                            bit_cnt_d = ACK_SLOT;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end else if (scl_fall) begin
                        sda_low_d = ~shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                    end
                end
                IGNORE: begin
                    sda_low_d = 1'b0;
                    busy_d    = 1'b0;
                end
                default: begin
                    state_d   = IDLE;
                    sda_low_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            own_addr_q  <= '0;
            sda_low_q   <= 1'b0;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            tx_load_q   <= 1'b0;
            busy_q      <= 1'b0;
            start_det_q <= 1'b0;
            stop_det_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            own_addr_q  <= own_addr_d;
            sda_low_q   <= sda_low_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            tx_load_q   <= tx_load_d;
            busy_q      <= busy_d;
            start_det_q <= start_det_d;
            stop_det_q  <= stop_det_d;
        end
    end

    // A repeated START must never find us still pulling the line low.
    assign sda_drive = sda_low_q & ~start_cond;
    assign I2C_SDA   = sda_drive ? 1'b0 : 1'bz;

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign tx_load   = tx_load_q;
    assign busy      = busy_q;
    assign start_det = start_det_q;
    assign stop_det  = stop_det_q;

endmodule

// File: doc/i2c_target_responder.md
Name: i2c_target_responder

Overview:
- I2C target (slave) that responds to an I2C controller on the same bus.
- Oversamples SCL/SDA on the system clock and detects START/STOP.
- Matches a 7-bit address, ACKs controller writes and delivers each byte to the host side.
- Serves read bytes from the host side; standard-mode compatible, no clock stretching.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on SCL and SDA inputs (min 2)
- FILT_LEN, 3, consecutive equal samples required by the glitch filter (used only with the optional feature)

Ports:
- clk  input  1  system clock, at least 20x SCL frequency
- rst  input  1  synchronous active-high reset
- I2C_SCL  input  1  bus clock from the controller
- I2C_SDA  inout  1  open-drain data line; driven 0 or 1'bz, never driven 1
- own_addr  input  7  target address; sampled at each START
- rx_data  output  8  last byte written by the controller
- rx_valid  output  1  one-cycle pulse when rx_data is updated
- rx_ready  input  1  host can accept a byte; sampled at the 8th data-bit rising edge
- tx_data  input  8  byte to return on a read
- tx_load  output  1  one-cycle pulse when tx_data is captured; host presents the next byte afterwards
- busy  output  1  high from address match until STOP or abandon
- start_det  output  1  one-cycle pulse per START / repeated START
- stop_det  output  1  one-cycle pulse per STOP

Behaviour:
- Reset: all outputs 0; rx_data 8'h00; SDA released (z); state IDLE.
- Reset mid-transfer releases SDA on the next clk.
- Edge and condition detection on synchronized samples:
  - scl_rise / scl_fall: edges of synchronized SCL.
  - START: SDA falls while SCL high. STOP: SDA rises while SCL high.
  - START/STOP override any state. START -> ADDR with bit counter cleared; STOP -> IDLE.
  - Both pulse their detect output one cycle after detection.
- SDA sampling and driving:
  - SDA is sampled on scl_rise.
  - The target changes its SDA drive only on the cycle after scl_fall.
- States:
  - IDLE: SDA released; wait for START.
  - ADDR: shift 8 bits MSB first on scl_rise. After the 8th bit, compare bits [7:1] with own_addr.
    - Match -> ADDR_ACK; busy=1.
    - Mismatch -> IGNORE.
  - ADDR_ACK: drive SDA 0 from the 8th falling edge until the 9th falling edge.
    - R/W=0 -> WRITE_BYTE.
    - R/W=1 -> capture tx_data, pulse tx_load, go to READ_BYTE.
  - WRITE_BYTE: shift 8 bits on scl_rise. On the 8th bit, rx_data updates and rx_valid pulses the next cycle.
    - rx_ready=1 -> WRITE_ACK (drive 0 for the 9th clock).
    - rx_ready=0 -> leave SDA released (NACK), then IGNORE.
  - WRITE_ACK: release SDA on the 9th falling edge -> WRITE_BYTE.
  - READ_BYTE: present the shift-register MSB on each falling edge, 8 bits. Bit value 1 = released, 0 = driven low.
  - READ_ACK: release SDA for the 9th clock; sample the controller's ACK on the 9th rising edge.
    - ACK (0) -> at the 9th falling edge capture tx_data, pulse tx_load, go to READ_BYTE.
    - NACK (1) -> IGNORE.
  - IGNORE: SDA released; busy=0; wait for START or STOP.
- Bit counter: 4 bits, 0..8; wraps to 0 on each byte/ACK boundary.
- Controller change of own_addr mid-transfer has no effect until the next START.
- Repeated START during READ_BYTE releases SDA on the same cycle the START is detected.

Optional Feature:
- Macro: I2C_TARGET_GLITCH_FILTER_EN.
- Defined: after the synchronizers, each of SCL and SDA passes a filter. The filtered value changes only after FILT_LEN consecutive equal samples. This adds FILT_LEN-1 cycles of latency to all detections; pulses below FILT_LEN cycles are ignored.
- Undefined: synchronizer outputs are used directly; FILT_LEN is unused.

Decomposition:
- Package i2c_pkg holds:
  - typedef enum logic [2:0] tgt_state_t {IDLE, ADDR, ADDR_ACK, WRITE_BYTE, WRITE_ACK, READ_BYTE, READ_ACK, IGNORE};
  - constants I2C_ACK=1'b0, I2C_NACK=1'b1, I2C_ADDR_W=7.
- One sub-module, i2c_line_sync: synchronizer, optional glitch filter and edge detect. Instantiated once for SCL and once for SDA; outputs level, rise, fall.

Test Plan:
- Address match write: own_addr=7'h50; controller sends START, 0xA0, 0x3C, STOP -> SDA low on both ACK clocks; rx_data=8'h3C with one rx_valid pulse; start_det and stop_det each pulse once; busy low after STOP.
- Address mismatch: own_addr=7'h50; controller sends 0xA2, 0x11 -> SDA never driven; no rx_valid; busy stays 0.
- Read two bytes: tx_data=8'hA5, then 8'h0F after the first tx_load; controller sends 0xA1, ACKs byte 1, NACKs byte 2 -> bus carries A5 then 0F; tx_load pulses twice; SDA released after the NACK.
- Host not ready: rx_ready=0 during write byte 0x77 -> 9th clock NACK; state IGNORE; no further ACKs until next START.
- Repeated START: write 0xA0, 0x01, then Sr, 0xA1, read 0xC3 -> start_det pulses twice; the read returns C3; no bus contention at Sr.
- Reset mid-read: rst asserted while driving a 0 bit -> SDA z on the next clk; outputs 0; the next START is handled normally.
